// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage load/store engine. Takes one load/store from the EX/MEM
//   register, runs it over a single-outstanding req/ack data bus, and
//   returns sign/zero-extended load data. The pipeline stalls until the
//   access completes.
//
// Optional feature macro: MISALIGN_EXC_EN
//   defined   : misaligned halfword/word accesses skip the bus and complete
//               straight away with addr_err=1.
//   undefined : offending low address bits are ignored, addr_err stays 0.
//
// Parameters
//   TIMEOUT_CYCLES  max WAIT cycles before bus_err (1..65535)
//   CNT_W           timeout counter width, 2**CNT_W > TIMEOUT_CYCLES
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   req_valid/op/addr/wdata     request from MEM stage (held while stall)
//   stall                       combinational, req_valid && state!=DONE
//   done, rdata, bus_err,
//   addr_err                    completion pulse + result/flags
//   mem_req/we/be/addr/wdata    data bus request (held until mem_ack)
//   mem_ack, mem_rdata          data bus response
module mem_access_unit #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        bus_err,
    output logic        addr_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int NUM_LANES = 4;

    localparam logic [2:0] OP_LB  = 3'd0;
    localparam logic [2:0] OP_LBU = 3'd1;
    localparam logic [2:0] OP_LH  = 3'd2;
    localparam logic [2:0] OP_LHU = 3'd3;
    localparam logic [2:0] OP_LW  = 3'd4;
    localparam logic [2:0] OP_SB  = 3'd5;
    localparam logic [2:0] OP_SH  = 3'd6;
    localparam logic [2:0] OP_SW  = 3'd7;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    logic [2:0]         op_q;
    logic [1:0]         addr_lo_q;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_nxt;

    logic [1:0]                   req_size;
    logic                         req_store;
    logic                         misalign_exc;
    logic [NUM_LANES-1:0]         lane_be;
    logic [NUM_LANES-1:0][7:0]    lane_wd;
    logic [7:0]                   ld_byte;
    logic [15:0]                  ld_half;
    logic [31:0]                  ld_val;
    logic                         op_q_store;

    assign stall      = req_valid && (state != DONE);
    assign cnt_nxt    = cnt + 1'b1;
    assign op_q_store = (op_q >= OP_SB);

    // Request decode: access size and direction.
    always_comb begin
        req_size  = SZ_W;
        req_store = (req_op >= OP_SB);
        case (req_op)
            OP_LB, OP_LBU, OP_SB: req_size = SZ_B;
            OP_LH, OP_LHU, OP_SH: req_size = SZ_H;
            default:              req_size = SZ_W;
        endcase
    end

    // Misalignment only matters when the exception is built in; otherwise
    // the low bits are simply not looked at by the lane logic.
`ifdef MISALIGN_EXC_EN
    always_comb begin
        misalign_exc = 1'b0;
        if (req_size == SZ_H)
            misalign_exc = req_addr[0];
        else if (req_size == SZ_W)
            misalign_exc = (req_addr[1:0] != 2'b00);
    end
`else
    assign misalign_exc = 1'b0;
`endif

    // Per byte lane (little-endian, lane 0 = bits [7:0]): store enable and
    // the store byte that lane carries. Bytes go to all four lanes, halves
    // to both halfword slots, so the memory just picks by byte enable.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [1:0] LI = 2'(i);
        assign lane_be[i] = (req_size == SZ_B) ? (req_addr[1:0] == LI) :
                            (req_size == SZ_H) ? (req_addr[1] == LI[1]) :
                                                 1'b1;
        assign lane_wd[i] = (req_size == SZ_B) ? req_wdata[7:0] :
                            (req_size == SZ_H) ? req_wdata[8*(i%2) +: 8] :
                                                 req_wdata[8*i +: 8];
    end

    // Load extraction from the returned word, using the registered op and
    // low address bits of the access in flight.
    always_comb begin
        ld_byte = mem_rdata[7:0];
        case (addr_lo_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (op_q)
            OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_val = {24'h0, ld_byte};
            OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_val = {16'h0, ld_half};
            default: ld_val = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= OP_LB;
            addr_lo_q <= 2'b00;
            cnt       <= '0;
            done      <= 1'b0;
            bus_err   <= 1'b0;
            addr_err  <= 1'b0;
            rdata     <= 32'h0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_be    <= 4'h0;
            mem_addr  <= 32'h0;
            mem_wdata <= 32'h0;
        end else begin
            case (state)
                IDLE: begin
                    done     <= 1'b0;
                    bus_err  <= 1'b0;
                    addr_err <= 1'b0;
                    if (req_valid) begin
                        op_q      <= req_op;
                        addr_lo_q <= req_addr[1:0];
                        cnt       <= '0;
                        if (misalign_exc) begin
                            // No bus traffic: report straight away.
                            state    <= DONE;
                            done     <= 1'b1;
                            addr_err <= 1'b1;
                        end else begin
                            state     <= WAIT;
                            mem_req   <= 1'b1;
                            mem_we    <= req_store;
                            mem_be    <= req_store ? lane_be : 4'b1111;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_wdata <= lane_wd;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt_nxt;
                    // Ack is checked first so it wins over a same-cycle timeout.
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (!op_q_store)
                            rdata <= ld_val;
                        state <= DONE;
                        done  <= 1'b1;
                    end else if (cnt_nxt == CNT_W'(TIMEOUT_CYCLES)) begin
                        mem_req <= 1'b0;
                        bus_err <= 1'b1;
                        state   <= DONE;
                        done    <= 1'b1;
                    end
                end
                DONE: begin
                    // req_valid is ignored here; the pipeline is advancing.
                    done     <= 1'b0;
                    bus_err  <= 1'b0;
                    addr_err <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit. The driver pushes the expected
// completion (rdata/bus_err/addr_err) into a queue when it issues a request;
// a negedge monitor pops and compares whenever done is seen. Bus-side
// behaviour (addresses, enables, hold, latency) is checked by the driver.
module tb_mem_access_unit;

    localparam int TMO = 6;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        bus_err;
    logic        addr_err;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    typedef struct {
        logic [31:0] rdata;
        logic        berr;
        logic        aerr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.TIMEOUT_CYCLES(TMO), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .bus_err   (bus_err),
        .addr_err  (addr_err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_be    (mem_be),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        exp_t e;
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_done actual=1 expected=0 rdata=%h", rdata);
            end else begin
                e = exp_q.pop_front();
                chk("done_rdata",    72'(rdata),    72'(e.rdata));
                chk("done_bus_err",  72'(bus_err),  72'(e.berr));
                chk("done_addr_err", 72'(addr_err), 72'(e.aerr));
            end
        end
    end

    // One access. ack_at = WAIT cycle carrying mem_ack (1 = first), 0 = never.
    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input int ack_at, input logic [31:0] word,
                          input bit bus, input logic [3:0] ebe, input logic [31:0] ewd,
                          input logic [31:0] erd, input logic eberr, input logic eaerr);
        exp_t        e;
        logic [69:0] ebus;
        int          n;
        e.rdata = erd;
        e.berr  = eberr;
        e.aerr  = eaerr;
        exp_q.push_back(e);
        ebus = {1'b1, (op >= 3'd5), ebe, addr[31:2], 2'b00, ewd};
        req_op    = op;
        req_addr  = addr;
        req_wdata = wd;
        req_valid = 1'b1;
        #1;
        chk($sformatf("%s_stall_accept", nm), 72'(stall), 72'(1));
        @(posedge clk); #1;
        if (bus) begin
            n = (ack_at == 0) ? TMO : ack_at;
            for (int w = 1; w <= n; w++) begin
                if (w == ack_at) begin
                    mem_ack   = 1'b1;
                    mem_rdata = word;
                end
                chk($sformatf("%s_bus_hold_w%0d", nm, w),
                    72'({mem_req, mem_we, mem_be, mem_addr, mem_wdata}), 72'(ebus));
                chk($sformatf("%s_stall_w%0d", nm, w), 72'(stall), 72'(1));
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                mem_rdata = 32'h0;
            end
        end else begin
            chk($sformatf("%s_no_bus_req", nm), 72'(mem_req), 72'(0));
        end
        chk($sformatf("%s_done_latency", nm), 72'(done), 72'(1));
        chk($sformatf("%s_stall_done", nm), 72'(stall), 72'(0));
        chk($sformatf("%s_req_dropped", nm), 72'(mem_req), 72'(0));
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk($sformatf("%s_done_one_cycle", nm), 72'(done), 72'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_flags", 72'({done, bus_err, addr_err, mem_req, mem_we, mem_be}), 72'(0));
        chk("reset_mem_addr",  72'(mem_addr),  72'(0));
        chk("reset_mem_wdata", 72'(mem_wdata), 72'(0));
        chk("reset_rdata",     72'(rdata),     72'(0));
        chk("reset_stall",     72'(stall),     72'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        //     name      op    addr          wdata         ack  word          bus be       ewdata        erdata        be ae
        run_op("lb",     3'd0, 32'h103,      32'h0,        1,   32'h80FF1234, 1, 4'b1111, 32'h0,        32'hFFFFFF80, 0, 0);
        run_op("lbu",    3'd1, 32'h103,      32'h0,        1,   32'h80FF1234, 1, 4'b1111, 32'h0,        32'h00000080, 0, 0);
        run_op("lh",     3'd2, 32'h2,        32'h0,        1,   32'h9ABC0000, 1, 4'b1111, 32'h0,        32'hFFFF9ABC, 0, 0);
        run_op("lhu",    3'd3, 32'h2,        32'h0,        1,   32'h9ABC0000, 1, 4'b1111, 32'h0,        32'h00009ABC, 0, 0);
        run_op("sb",     3'd5, 32'h41,       32'h000000A5, 1,   32'hDEADBEEF, 1, 4'b0010, 32'hA5A5A5A5, 32'h00009ABC, 0, 0);
        run_op("lb_pos", 3'd0, 32'h0,        32'h0,        1,   32'h1234567F, 1, 4'b1111, 32'h0,        32'h0000007F, 0, 0);
        run_op("sh",     3'd6, 32'h2,        32'h0000BEEF, 1,   32'h0,        1, 4'b1100, 32'hBEEFBEEF, 32'h0000007F, 0, 0);
        run_op("sw",     3'd7, 32'h8,        32'h11223344, 1,   32'h0,        1, 4'b1111, 32'h11223344, 32'h0000007F, 0, 0);
        run_op("lw_dly", 3'd4, 32'h200,      32'h0,        5,   32'h12345678, 1, 4'b1111, 32'h0,        32'h12345678, 0, 0);
        run_op("lw_tmo", 3'd4, 32'h204,      32'h0,        0,   32'h0,        1, 4'b1111, 32'h0,        32'h12345678, 1, 0);
        run_op("lw_edge",3'd4, 32'h300,      32'h0,        TMO, 32'hCAFEF00D, 1, 4'b1111, 32'h0,        32'hCAFEF00D, 0, 0);

        // Stray ack while idle is ignored.
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        chk("idle_ack_no_req", 72'(mem_req), 72'(0));
        @(posedge clk); #1;
        chk("idle_ack_no_done", 72'(done), 72'(0));
        chk("idle_ack_rdata",   72'(rdata), 72'(32'hCAFEF00D));

        // Reset during WAIT, ack one cycle later.
        req_op    = 3'd4;
        req_addr  = 32'h400;
        req_wdata = 32'h0;
        req_valid = 1'b1;
        @(posedge clk); #1;
        chk("abort_req_up", 72'(mem_req), 72'(1));
        reset     = 1'b1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset     = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h55555555;
        chk("abort_req_down", 72'(mem_req), 72'(0));
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        mem_rdata = 32'h0;
        chk("abort_no_done",  72'(done),    72'(0));
        chk("abort_req_low",  72'(mem_req), 72'(0));
        chk("abort_rdata",    72'(rdata),   72'(0));
        @(posedge clk); #1;
        chk("abort_still_no_done", 72'(done), 72'(0));

        run_op("lw_after", 3'd4, 32'h404, 32'h0, 2, 32'h0BADC0DE, 1, 4'b1111, 32'h0, 32'h0BADC0DE, 0, 0);

`ifdef MISALIGN_EXC_EN
        run_op("sh_mis", 3'd6, 32'h7,   32'h00001234, 1, 32'h0,        0, 4'b0000, 32'h0,        32'h0BADC0DE, 0, 1);
        run_op("lw_mis", 3'd4, 32'h501, 32'h0,        1, 32'hA1B2C3D4, 0, 4'b0000, 32'h0,        32'h0BADC0DE, 0, 1);
`else
        run_op("sh_mis", 3'd6, 32'h7,   32'h00001234, 1, 32'h0,        1, 4'b1100, 32'h12341234, 32'h0BADC0DE, 0, 0);
        run_op("lw_mis", 3'd4, 32'h501, 32'h0,        1, 32'hA1B2C3D4, 1, 4'b1111, 32'h0,        32'hA1B2C3D4, 0, 0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 72'(exp_q.size()), 72'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store engine of the MIPS core, between the EX/MEM pipeline register and the data-memory bus.
- Accepts one load/store per request, drives a single-outstanding request/ack bus, and generates byte enables for stores.
- For loads, extracts the addressed byte or halfword and sign- or zero-extends it to 32 bits before writeback.
- Stalls the pipeline until the access completes.

Parameters:
- TIMEOUT_CYCLES, 255, maximum cycles in WAIT before a bus error is reported; valid range 1..65535.
- CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  MEM stage holds a load/store; held stable by the pipeline while stall=1.
- req_op  input  3  0=LB 1=LBU 2=LH 3=LHU 4=LW 5=SB 6=SH 7=SW.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- stall  output  1  combinational: req_valid && state!=DONE.
- done  output  1  one-cycle completion pulse.
- rdata  output  32  extended load result.
- bus_err  output  1  timeout flag, valid with done.
- addr_err  output  1  misalignment flag, valid with done; tied 0 when the optional feature is off.
- mem_req  output  1  bus request.
- mem_we  output  1  write enable.
- mem_be  output  4  byte enables.
- mem_addr  output  32  word address; bits [1:0] always 0.
- mem_wdata  output  32  lane-replicated store data.
- mem_ack  input  1  bus completion; single cycle, only meaningful while mem_req=1.
- mem_rdata  input  32  read word, valid when mem_ack=1.

Behaviour:
- Reset values: state=IDLE; done, bus_err, addr_err, mem_req, mem_we all 0; mem_be=0; mem_addr, mem_wdata, rdata all 0; timeout counter 0.
- IDLE:
  - On req_valid, register op, addr and wdata, then go to WAIT with mem_req=1 from the next cycle.
  - Byte lanes are little-endian: addr[1:0]=0 selects bits [7:0].
  - Byte enables: SB -> 4'b0001<<addr[1:0]; SH -> 4'b0011<<{addr[1],1'b0}; SW -> 4'b1111. Loads drive mem_be=4'b1111.
  - Store data: byte replicated x4, halfword replicated x2.
- WAIT:
  - mem_req, mem_we, mem_be, mem_addr and mem_wdata are held constant until mem_ack.
  - On mem_ack: deassert mem_req, latch the load result into rdata, go to DONE. Stores leave rdata unchanged.
  - Counter increments each WAIT cycle. On reaching TIMEOUT_CYCLES without ack: deassert mem_req, set bus_err=1, go to DONE.
- DONE:
  - done=1 for exactly one cycle; stall=0 so the pipeline advances.
  - req_valid is ignored in this cycle. Next state is IDLE. Error flags clear on leaving DONE.
- Load extension:
  - LB/LH replicate the sign bit of the selected byte/halfword; LBU/LHU zero-fill; LW passes the word through.
  - Halfword is selected by addr[1].
- Latency: minimum 3 cycles from accept to done (accept, WAIT with immediate ack, DONE). stall is high in the accept cycle and every WAIT cycle.
- An ack arriving in IDLE or DONE is ignored.
- A reset asserted in any state returns to IDLE at that edge. mem_req is low from the next cycle; no done pulse is generated for the aborted access.
- A timeout and an ack in the same cycle: the ack wins and bus_err=0.

Optional Feature:
- MISALIGN_EXC_EN defined:
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0, issues no bus request.
  - The unit goes IDLE -> DONE directly, with addr_err=1 and done=1 in the cycle after accept; rdata is unchanged.
- Undefined: the offending low address bits are ignored (halfword uses addr[1], word uses none), the access proceeds normally, and addr_err stays 0.

Test Plan:
- LB at addr 0x103, mem_rdata=0x80FF1234 with ack on the first WAIT cycle -> mem_addr=0x100, mem_be=4'b1111, done on cycle 3, rdata=0xFFFFFF80. Repeat as LBU -> rdata=0x00000080.
- LH at addr 0x2, mem_rdata=0x9ABC0000 -> rdata=0xFFFF9ABC. LHU -> rdata=0x00009ABC.
- SB at addr 0x41, wdata=0x000000A5 -> mem_we=1, mem_be=4'b0010, mem_wdata=0xA5A5A5A5, mem_addr=0x40.
- LW with ack delayed 5 cycles -> mem_req and all bus outputs stable for 5 cycles, stall high for 6 cycles, done on the 7th. With ack withheld and TIMEOUT_CYCLES=4 -> bus_err=1 with done, mem_req low afterwards.
- reset asserted in WAIT, ack asserted one cycle later -> mem_req=0, no done pulse, state IDLE; the next LW completes normally.
- With MISALIGN_EXC_EN, SH at addr 0x7 -> mem_req never asserted, addr_err=1 and done=1 in the cycle after accept. Without the macro -> mem_be=4'b1100, addr_err=0.
